avl_map_read_responder: RTL and testbench

//  Avalon-MM slave read path: the read-side counterpart of the map-write passthrough.

---
 rtl/avl_map_read_responder.sv | 119 +++++++++++
 tb/tb_avl_map_read_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/avl_map_read_responder.sv
// Avalon-MM read responder for the tile-map RAM and the hero/status registers.
// Fixed-latency pipeline with write forwarding and render-port stall handling.
module avl_map_read_responder #(
    parameter int          RAM_LATENCY = 1,
    parameter int          MAP_DEPTH   = 240,
    parameter logic [7:0]  REG_BASE    = 8'hF0,
    parameter logic [7:0]  VERSION     = 8'h01
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       AVL_CS,
    input  logic       AVL_READ,
    input  logic       AVL_WRITE,
    input  logic [7:0] AVL_ADDR,
    input  logic [7:0] AVL_WRITEDATA,
    output logic       AVL_WAITREQUEST,
    output logic [7:0] AVL_READDATA,
    output logic       AVL_READDATAVALID,
    output logic       MAP_READ_REQ,
    output logic [7:0] MAP_READ_ADDR,
    input  logic       MAP_READ_GRANT,
    input  logic [7:0] MAP_READ_DATA,
    input  logic [7:0] HERO_X,
    input  logic [7:0] HERO_Y
);

    typedef struct packed {
        logic       valid;
        logic       is_map;
        logic       fwd_hit;
        logic [7:0] data;
    } stage_t;

    localparam logic [8:0] MAP_TOP = 9'(MAP_DEPTH);
    localparam logic [7:0] REG_X   = REG_BASE;
    localparam logic [7:0] REG_Y   = REG_BASE + 8'd1;
    localparam logic [7:0] REG_VER = REG_BASE + 8'd2;
    localparam int         LAST    = RAM_LATENCY - 1;

    logic       rd;
    logic       is_map;
    logic       accept;
    logic       fwd_hit;
    logic [7:0] reg_data;
    stage_t     entry;

    logic       fwd_valid;
    logic [7:0] fwd_addr;
    logic [7:0] fwd_data;

    stage_t     pipe [RAM_LATENCY];

    assign rd     = AVL_CS & AVL_READ;
    assign is_map = {1'b0, AVL_ADDR} < MAP_TOP;

    assign AVL_WAITREQUEST = rd & (AVL_WRITE | (is_map & ~MAP_READ_GRANT));
    assign accept          = rd & ~AVL_WAITREQUEST;

    assign MAP_READ_REQ  = rd & ~AVL_WRITE & is_map;
    assign MAP_READ_ADDR = AVL_ADDR;

    // RAM is read-during-write-old, so only the write from the previous cycle is missing
    assign fwd_hit = is_map & fwd_valid & (fwd_addr == AVL_ADDR);

    always_comb begin
        reg_data = 8'h00;
        unique case (1'b1)
            is_map:                reg_data = 8'h00;
            (AVL_ADDR == REG_X):   reg_data = HERO_X;
            (AVL_ADDR == REG_Y):   reg_data = HERO_Y;
            (AVL_ADDR == REG_VER): reg_data = VERSION;
            default:               reg_data = 8'h00;
        endcase
    end

    always_comb begin
        entry         = '0;
        entry.valid   = accept;
        entry.is_map  = is_map;
        entry.fwd_hit = fwd_hit;
        entry.data    = fwd_hit ? fwd_data : reg_data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= 8'h00;
            fwd_data  <= 8'h00;
        end else begin
            fwd_valid <= AVL_CS & AVL_WRITE;
            if (AVL_CS & AVL_WRITE) begin
                fwd_addr <= AVL_ADDR;
                fwd_data <= AVL_WRITEDATA;
            end
        end
    end

    // The last stage lines up with MAP_READ_DATA; the output register adds the final cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                pipe[k] <= '0;
            end
            AVL_READDATAVALID <= 1'b0;
            AVL_READDATA      <= 8'h00;
        end else begin
            pipe[0] <= entry;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
            AVL_READDATAVALID <= pipe[LAST].valid;
            if (pipe[LAST].valid) begin
                AVL_READDATA <= (pipe[LAST].is_map & ~pipe[LAST].fwd_hit)
                              ? MAP_READ_DATA : pipe[LAST].data;
            end
        end
    end

endmodule

// File: tb/tb_avl_map_read_responder.sv
// Scoreboard bench for avl_map_read_responder.
// Directed reads push expectations; a negedge monitor pops on READDATAVALID.
module tb_avl_map_read_responder;

    localparam int LAT = 1;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       AVL_CS = 1'b0;
    logic       AVL_READ = 1'b0;
    logic       AVL_WRITE = 1'b0;
    logic [7:0] AVL_ADDR = 8'h00;
    logic [7:0] AVL_WRITEDATA = 8'h00;
    logic       AVL_WAITREQUEST;
    logic [7:0] AVL_READDATA;
    logic       AVL_READDATAVALID;
    logic       MAP_READ_REQ;
    logic [7:0] MAP_READ_ADDR;
    logic       MAP_READ_GRANT = 1'b1;
    logic [7:0] MAP_READ_DATA = 8'h00;
    logic [7:0] HERO_X = 8'h00;
    logic [7:0] HERO_Y = 8'h00;

    avl_map_read_responder #(.RAM_LATENCY(LAT)) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .AVL_CS            (AVL_CS),
        .AVL_READ          (AVL_READ),
        .AVL_WRITE         (AVL_WRITE),
        .AVL_ADDR          (AVL_ADDR),
        .AVL_WRITEDATA     (AVL_WRITEDATA),
        .AVL_WAITREQUEST   (AVL_WAITREQUEST),
        .AVL_READDATA      (AVL_READDATA),
        .AVL_READDATAVALID (AVL_READDATAVALID),
        .MAP_READ_REQ      (MAP_READ_REQ),
        .MAP_READ_ADDR     (MAP_READ_ADDR),
        .MAP_READ_GRANT    (MAP_READ_GRANT),
        .MAP_READ_DATA     (MAP_READ_DATA),
        .HERO_X            (HERO_X),
        .HERO_Y            (HERO_Y)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         c;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] ram [256];

    always @(posedge CLK) cyc <= cyc + 1;

    // One-cycle-latency RAM behind the arbiter; CPU writes do not land here
    always @(posedge CLK) begin
        if (MAP_READ_REQ && MAP_READ_GRANT) MAP_READ_DATA <= ram[MAP_READ_ADDR];
    end

    always @(negedge CLK) begin
        if (AVL_READDATAVALID) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: data %02h at cycle %0d, none expected",
                         AVL_READDATA, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (AVL_READDATA !== e.d || cyc != e.c) begin
                    fails++;
                    $display("FAIL %s: got %02h at cycle %0d, want %02h at cycle %0d",
                             e.nm, AVL_READDATA, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %02h want %02h", nm, got, want);
        end
    endtask

    task automatic idle();
        AVL_CS    = 1'b0;
        AVL_READ  = 1'b0;
        AVL_WRITE = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] want,
                           input bit no_wait, input string nm);
        int n;
        n = 0;
        AVL_CS    = 1'b1;
        AVL_READ  = 1'b1;
        AVL_WRITE = 1'b0;
        AVL_ADDR  = a;
        @(negedge CLK);
        while (AVL_WAITREQUEST && n < 20) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            n++;
        end
        tests++;
        if (AVL_WAITREQUEST || (no_wait && n != 0)) begin
            fails++;
            $display("FAIL %s_accept: waited %0d cycles, want %0d", nm, n, 0);
        end
        if (!AVL_WAITREQUEST) sb.push_back('{want, cyc + LAT + 1, nm});
        @(posedge CLK); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i + 8'h40);
        ram[8'h05] = 8'h3C;
        ram[8'h10] = 8'h00;
        ram[8'h20] = 8'h99;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_valid", {7'b0, AVL_READDATAVALID}, 8'h00);
        check("reset_data", AVL_READDATA, 8'h00);
        check("reset_wait", {7'b0, AVL_WAITREQUEST}, 8'h00);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        do_read(8'h05, 8'h3C, 1'b1, "t1_read05");
        idle();
        repeat (3) @(posedge CLK);
        #1;

        do_read(8'h00, 8'h40, 1'b1, "t2_b2b_00");
        do_read(8'h01, 8'h41, 1'b1, "t2_b2b_01");
        do_read(8'h02, 8'h42, 1'b1, "t2_b2b_02");
        do_read(8'h03, 8'h43, 1'b1, "t2_b2b_03");
        idle();
        repeat (3) @(posedge CLK);
        #1;

        MAP_READ_GRANT = 1'b0;
        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = 8'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t3_wait_no_grant", {7'b0, AVL_WAITREQUEST}, 8'h01);
            @(posedge CLK); #1;
        end
        MAP_READ_GRANT = 1'b1;
        do_read(8'h20, 8'h99, 1'b1, "t3_after_grant");
        idle();
        repeat (3) @(posedge CLK);
        #1;

        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = 8'h10;
        AVL_WRITEDATA = 8'hAA;
        @(posedge CLK); #1;
        do_read(8'h10, 8'hAA, 1'b1, "t4_forward");
        ram[8'h10] = 8'h55;
        do_read(8'h10, 8'h55, 1'b1, "t4_no_forward");
        idle();
        repeat (3) @(posedge CLK);
        #1;

        HERO_X = 8'h12;
        HERO_Y = 8'h34;
        do_read(8'hF0, 8'h12, 1'b1, "t5_hero_x");
        do_read(8'hF1, 8'h34, 1'b1, "t5_hero_y");
        do_read(8'hF2, 8'h01, 1'b1, "t5_version");
        do_read(8'hF7, 8'h00, 1'b1, "t5_unmapped");
        do_read(8'hFF, 8'h00, 1'b1, "t5_addr_ff");
        AVL_CS    = 1'b1;
        AVL_READ  = 1'b1;
        AVL_WRITE = 1'b1;
        AVL_ADDR  = 8'h30;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("t5_rw_wait", {7'b0, AVL_WAITREQUEST}, 8'h01);
            check("t5_rw_no_map_req", {7'b0, MAP_READ_REQ}, 8'h00);
            @(posedge CLK); #1;
        end
        idle();
        repeat (4) @(posedge CLK);
        #1;

        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = 8'h01;
        @(posedge CLK); #1;
        AVL_ADDR = 8'h02;
        @(negedge CLK);
        RESET_N = 1'b0;
        idle();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("t6_reset_valid", {7'b0, AVL_READDATAVALID}, 8'h00);
        check("t6_reset_data", AVL_READDATA, 8'h00);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        do_read(8'h05, 8'h3C, 1'b1, "t6_after_reset");
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses missing, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
